// File: rtl/line_buffer_ctrl.sv
// Circular line-buffer sequencer: writes the stream into the oldest of NUM_RAMS line RAMs and
// emits a vertical column of NUM_RAMS+1 pixels per accepted input pixel.
module line_buffer_ctrl #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned NUM_RAMS   = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 frame_start_i,
  input  logic [ADDR_WIDTH:0]                  line_width_i,
  input  logic                                 pix_valid_i,
  input  logic [DATA_WIDTH-1:0]                pix_data_i,
  output logic                                 pix_ready_o,
  output logic [NUM_RAMS-1:0]                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]                ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]                ram_wr_data_o,
  output logic                                 ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0]                ram_rd_addr_o,
  input  logic [NUM_RAMS*DATA_WIDTH-1:0]       ram_rd_data_i,
  output logic                                 col_valid_o,
  input  logic                                 col_ready_i,
  output logic [(NUM_RAMS+1)*DATA_WIDTH-1:0]   col_data_o,
  output logic [ADDR_WIDTH-1:0]                col_x_o,
  output logic                                 col_eol_o
);

  localparam int unsigned SelW = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;
  localparam int unsigned CntW = $clog2(NUM_RAMS + 1);
  localparam logic [ADDR_WIDTH:0] WidthOne = 1;

  typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH:0]   r_width;
  logic [ADDR_WIDTH-1:0] r_x;
  logic [CntW-1:0]       r_line_cnt;
  logic [SelW-1:0]       r_wr_sel;
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_pix;
  logic [ADDR_WIDTH-1:0] r_s1_x;
  logic                  r_s1_eol;
  logic [SelW-1:0]       r_s1_sel;

  logic w_start, w_eol, w_ready, w_accept, w_last_fill;

  assign w_start     = frame_start_i && (line_width_i != '0);
  assign w_eol       = ({1'b0, r_x} == (r_width - WidthOne));
  assign w_last_fill = (r_line_cnt == CntW'(NUM_RAMS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = StFill;
    end else if (r_state == StFill && w_accept && w_eol && w_last_fill) begin
      w_state_next = StStream;
    end
  end

  // RAM enables follow the handshake directly so read data holds across stalls.
  always_comb begin
    w_ready       = (r_state != StIdle) && !frame_start_i && (!r_s1_valid || col_ready_i);
    w_accept      = w_ready && pix_valid_i;
    pix_ready_o   = w_ready;
    ram_wr_en_o   = '0;
    if (w_accept) begin
      ram_wr_en_o[r_wr_sel] = 1'b1;
    end
    ram_wr_addr_o = r_x;
    ram_wr_data_o = pix_data_i;
    ram_rd_en_o   = w_accept;
    ram_rd_addr_o = r_x;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_width    <= '0;
      r_x        <= '0;
      r_line_cnt <= '0;
      r_wr_sel   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_x     <= '0;
      r_s1_eol   <= 1'b0;
      r_s1_sel   <= '0;
    end else if (w_start) begin
      r_width    <= line_width_i;
      r_x        <= '0;
      r_line_cnt <= '0;
      r_wr_sel   <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_eol) begin
          r_x      <= '0;
          r_wr_sel <= (r_wr_sel == SelW'(NUM_RAMS - 1)) ? '0 : r_wr_sel + SelW'(1);
          if (r_line_cnt != CntW'(NUM_RAMS)) begin
            r_line_cnt <= r_line_cnt + CntW'(1);
          end
        end else begin
          r_x <= r_x + ADDR_WIDTH'(1);
        end
      end
      if (w_accept && r_state == StStream) begin
        r_s1_valid <= 1'b1;
        r_s1_pix   <= pix_data_i;
        r_s1_x     <= r_x;
        r_s1_eol   <= w_eol;
        r_s1_sel   <= r_wr_sel;
      end else if (col_ready_i) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Row y-j lives in RAM (sel-j) mod NUM_RAMS; row y-NUM_RAMS is the one just overwritten.
  always_comb begin
    int unsigned idx;
    idx = 0;
    col_data_o = '0;
    col_data_o[DATA_WIDTH-1:0] = r_s1_pix;
    for (int unsigned j = 1; j <= NUM_RAMS; j++) begin
      idx = (int'(r_s1_sel) + NUM_RAMS - j) % NUM_RAMS;
      col_data_o[j*DATA_WIDTH +: DATA_WIDTH] = ram_rd_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign col_valid_o = r_s1_valid;
  assign col_x_o     = r_s1_x;
  assign col_eol_o   = r_s1_eol;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a behavioural model of the external line RAMs.
module tb_line_buffer_ctrl;
  localparam int DW = 14;
  localparam int AW = 11;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic [AW:0]       line_width;
  logic              pix_valid;
  logic [DW-1:0]     pix_data;
  logic              pix_ready;
  logic [NR-1:0]     ram_wr_en;
  logic [AW-1:0]     ram_wr_addr;
  logic [DW-1:0]     ram_wr_data;
  logic              ram_rd_en;
  logic [AW-1:0]     ram_rd_addr;
  logic [NR*DW-1:0]  ram_rd_data = '0;
  logic              col_valid;
  logic              col_ready;
  logic [(NR+1)*DW-1:0] col_data;
  logic [AW-1:0]     col_x;
  logic              col_eol;

  int n_checks = 0;
  int n_pass = 0;

  line_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RAMS(NR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(frame_start), .line_width_i(line_width),
    .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_ready_o(pix_ready),
    .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data),
    .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data),
    .col_valid_o(col_valid), .col_ready_i(col_ready), .col_data_o(col_data),
    .col_x_o(col_x), .col_eol_o(col_eol)
  );

  always #5 clk = ~clk;

  // Line RAMs: registered read of pre-write contents, output held when not read.
  logic [DW-1:0] mem [NR][2**AW];
  always @(posedge clk) begin
    for (int k = 0; k < NR; k++) begin
      if (ram_rd_en) ram_rd_data[k*DW +: DW] <= mem[k][ram_rd_addr];
      if (ram_wr_en[k]) mem[k][ram_wr_addr] <= ram_wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int w);
    frame_start = 1'b1;
    line_width  = (AW+1)'(w);
    pix_valid   = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_quiet(input int first, input int count);
    for (int n = first; n < first + count; n++) begin
      pix_valid = 1'b1;
      pix_data  = DW'(n);
      tick();
    end
  endtask

  function automatic logic [(NR+1)*DW-1:0] col3(input int a0, input int a1, input int a2);
    logic [DW-1:0] b0, b1, b2;
    b0 = a0[DW-1:0];
    b1 = a1[DW-1:0];
    b2 = a2[DW-1:0];
    return {b2, b1, b0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 1'b0; line_width = '0; pix_valid = 1'b0; pix_data = '0;
    col_ready = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    pix_valid = 1'b1;
    #1;
    n_checks++; if (pix_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", pix_ready); else n_pass++;
    n_checks++; if (col_valid !== 1'b0) $display("FAIL reset_col_valid: got %b expected 0", col_valid); else n_pass++;
    n_checks++; if (ram_wr_en !== '0) $display("FAIL reset_wr_en: got %b expected 00", ram_wr_en); else n_pass++;
    n_checks++; if (ram_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", ram_rd_en); else n_pass++;
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_fill_stream();
    logic [NR-1:0] exp_en;
    start_frame(4);
    col_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      pix_valid = 1'b1; pix_data = DW'(n);
      exp_en = '0; exp_en[(n/4)%2] = 1'b1;
      #1;
      n_checks++; if (pix_ready !== 1'b1) $display("FAIL fill_ready n=%0d: got %b expected 1", n, pix_ready); else n_pass++;
      n_checks++; if (ram_wr_en !== exp_en) $display("FAIL fill_wr_en n=%0d: got %b expected %b", n, ram_wr_en, exp_en); else n_pass++;
      n_checks++; if (ram_rd_addr !== AW'(n%4)) $display("FAIL fill_rd_addr n=%0d: got %0d expected %0d", n, ram_rd_addr, n%4); else n_pass++;
      tick();
      n_checks++; if (col_valid !== (n >= 8)) $display("FAIL fill_col_valid n=%0d: got %b expected %b", n, col_valid, n >= 8); else n_pass++;
      if (n >= 8) begin
        n_checks++; if (col_data !== col3(n, n-4, n-8)) $display("FAIL fill_col_data n=%0d: got %h expected %h", n, col_data, col3(n, n-4, n-8)); else n_pass++;
        n_checks++; if (col_x !== AW'(n%4)) $display("FAIL fill_col_x n=%0d: got %0d expected %0d", n, col_x, n%4); else n_pass++;
        n_checks++; if (col_eol !== (n%4 == 3)) $display("FAIL fill_col_eol n=%0d: got %b expected %b", n, col_eol, n%4 == 3); else n_pass++;
      end
    end
  endtask

  task automatic test_rotation();
    logic [NR-1:0] exp_en;
    for (int n = 12; n < 20; n++) begin
      pix_valid = 1'b1; pix_data = DW'(n);
      exp_en = '0; exp_en[(n/4)%2] = 1'b1;
      #1;
      n_checks++; if (ram_wr_en !== exp_en) $display("FAIL rot_wr_en n=%0d: got %b expected %b", n, ram_wr_en, exp_en); else n_pass++;
      tick();
      n_checks++; if (col_data !== col3(n, n-4, n-8)) $display("FAIL rot_col_data n=%0d: got %h expected %h", n, col_data, col3(n, n-4, n-8)); else n_pass++;
    end
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    start_frame(4);
    col_ready = 1'b1;
    send_quiet(0, 10);
    col_ready = 1'b0; pix_valid = 1'b1; pix_data = DW'(10);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (pix_ready !== 1'b0) $display("FAIL bp_ready c=%0d: got %b expected 0", c, pix_ready); else n_pass++;
      n_checks++; if (ram_wr_en !== '0 || ram_rd_en !== 1'b0) $display("FAIL bp_enables c=%0d: got %b/%b expected 00/0", c, ram_wr_en, ram_rd_en); else n_pass++;
      tick();
      n_checks++; if (col_valid !== 1'b1) $display("FAIL bp_col_valid c=%0d: got %b expected 1", c, col_valid); else n_pass++;
      n_checks++; if (col_data !== col3(9, 5, 1)) $display("FAIL bp_col_data c=%0d: got %h expected %h", c, col_data, col3(9, 5, 1)); else n_pass++;
      n_checks++; if (col_x !== AW'(1)) $display("FAIL bp_col_x c=%0d: got %0d expected 1", c, col_x); else n_pass++;
    end
    col_ready = 1'b1;
    #1;
    n_checks++; if (pix_ready !== 1'b1) $display("FAIL bp_resume_ready: got %b expected 1", pix_ready); else n_pass++;
    tick();
    n_checks++; if (col_data !== col3(10, 6, 2) || col_x !== AW'(2)) $display("FAIL bp_resume_col: got %h x=%0d expected %h x=2", col_data, col_x, col3(10, 6, 2)); else n_pass++;
    pix_data = DW'(11);
    tick();
    n_checks++; if (col_data !== col3(11, 7, 3) || col_eol !== 1'b1) $display("FAIL bp_eol_col: got %h eol=%b expected %h eol=1", col_data, col_eol, col3(11, 7, 3)); else n_pass++;
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_restart();
    start_frame(4);
    col_ready = 1'b1;
    send_quiet(0, 10);
    frame_start = 1'b1; line_width = (AW+1)'(4); pix_valid = 1'b1; pix_data = DW'(99);
    col_ready = 1'b0;
    #1;
    n_checks++; if (pix_ready !== 1'b0) $display("FAIL restart_ready: got %b expected 0", pix_ready); else n_pass++;
    n_checks++; if (ram_wr_en !== '0) $display("FAIL restart_wr_en: got %b expected 00", ram_wr_en); else n_pass++;
    tick();
    frame_start = 1'b0;
    n_checks++; if (col_valid !== 1'b0) $display("FAIL restart_drop: got %b expected 0", col_valid); else n_pass++;
    col_ready = 1'b1;
    for (int n = 0; n < 9; n++) begin
      pix_data = DW'(100 + n);
      #1;
      if (n == 0) begin
        n_checks++; if (ram_wr_addr !== '0) $display("FAIL restart_addr: got %0d expected 0", ram_wr_addr); else n_pass++;
      end
      tick();
      if (n < 8) begin
        n_checks++; if (col_valid !== 1'b0) $display("FAIL restart_fill n=%0d: got %b expected 0", n, col_valid); else n_pass++;
      end else begin
        n_checks++; if (col_data !== col3(108, 104, 100)) $display("FAIL restart_col: got %h expected %h", col_data, col3(108, 104, 100)); else n_pass++;
      end
    end
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    start_frame(4);
    col_ready = 1'b1;
    send_quiet(0, 9);
    pix_valid = 1'b1; pix_data = DW'(9);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (col_valid !== 1'b0) $display("FAIL areset_col_valid: got %b expected 0", col_valid); else n_pass++;
    n_checks++; if (pix_ready !== 1'b0) $display("FAIL areset_ready: got %b expected 0", pix_ready); else n_pass++;
    n_checks++; if (ram_wr_en !== '0 || ram_rd_en !== 1'b0) $display("FAIL areset_enables: got %b/%b expected 00/0", ram_wr_en, ram_rd_en); else n_pass++;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (pix_ready !== 1'b0) $display("FAIL areset_idle c=%0d: got %b expected 0", c, pix_ready); else n_pass++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_edge_widths();
    frame_start = 1'b1; line_width = '0;
    tick();
    frame_start = 1'b0; pix_valid = 1'b1;
    #1;
    n_checks++; if (pix_ready !== 1'b0) $display("FAIL width0_idle: got %b expected 0", pix_ready); else n_pass++;
    start_frame(1);
    col_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      pix_valid = 1'b1; pix_data = DW'(200 + n);
      #1;
      n_checks++; if (ram_wr_addr !== '0) $display("FAIL w1_addr n=%0d: got %0d expected 0", n, ram_wr_addr); else n_pass++;
      tick();
      if (n < 2) begin
        n_checks++; if (col_valid !== 1'b0) $display("FAIL w1_fill n=%0d: got %b expected 0", n, col_valid); else n_pass++;
      end else begin
        n_checks++; if (col_data !== col3(200+n, 199+n, 198+n) || col_eol !== 1'b1 || col_x !== '0)
          $display("FAIL w1_col n=%0d: got %h eol=%b x=%0d expected %h eol=1 x=0", n, col_data, col_eol, col_x, col3(200+n, 199+n, 198+n));
        else n_pass++;
      end
    end
    start_frame(2048);
    for (int n = 0; n <= 6144; n++) begin
      pix_valid = 1'b1; pix_data = DW'(n);
      tick();
      if (n == 6143) begin
        n_checks++; if (col_data !== col3(6143, 4095, 2047) || col_x !== AW'(2047) || col_eol !== 1'b1)
          $display("FAIL w2048_last: got %h x=%0d eol=%b expected %h x=2047 eol=1", col_data, col_x, col_eol, col3(6143, 4095, 2047));
        else n_pass++;
      end
      if (n == 6144) begin
        n_checks++; if (col_data !== col3(6144, 4096, 2048) || col_x !== '0 || col_eol !== 1'b0)
          $display("FAIL w2048_wrap: got %h x=%0d eol=%b expected %h x=0 eol=0", col_data, col_x, col_eol, col3(6144, 4096, 2048));
        else n_pass++;
      end
    end
    pix_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_stream();
    test_rotation();
    test_backpressure();
    test_restart();
    test_async_reset();
    test_edge_widths();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
